// File: rtl/exst_mem_pipe_stage.sv
// EX/ST -> MEM pipeline stage: valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush. Payload is {mem_addr, rdest_addr, data, store, pc_wr}.
module exst_mem_pipe_stage #(
  parameter int ADDR_W  = 16,
  parameter int RADDR_W = 3,
  parameter int DATA_W  = 32,
  parameter bit SKID    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADDR_W-1:0]  mem_addr_in,
  input  logic [RADDR_W-1:0] rdest_addr_in,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               store_in,
  input  logic               pc_wr_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  mem_addr_out,
  output logic [RADDR_W-1:0] rdest_addr_out,
  output logic [DATA_W-1:0]  data_out,
  output logic               store_out,
  output logic               pc_wr_out,
  output logic [1:0]         occupancy
);

  localparam int PW = ADDR_W + RADDR_W + DATA_W + 2;

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, HALF = 2'd1, FULL = 2'd2} state_e;

  state_e          state_q;
  logic [PW-1:0]   main_q, skid_q;
  logic            rdy_q;
  logic [PW-1:0]   in_p;
  logic            push, pop;
  logic            head_st, head_pc;

  assign in_p      = {mem_addr_in, rdest_addr_in, data_in, store_in, pc_wr_in};
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  generate
    if (SKID) begin : g_skid
      // Registered ready: no combinational path from out_ready.
      assign in_ready = rdy_q & ~reset;
    end else begin : g_noskid
      assign in_ready = (~out_valid | out_ready) & ~reset;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b1;
    end else if (flush) begin
      // Payload regs keep their values; only the valid state is squashed.
      state_q <= EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          main_q  <= in_p;
          state_q <= HALF;
        end
        HALF: begin
          if (push && pop) begin
            main_q <= in_p;
          end else if (push) begin
            skid_q  <= in_p;
            state_q <= FULL;
            rdy_q   <= 1'b0;
          end else if (pop) begin
            state_q <= EMPTY;
          end
        end
        FULL: if (pop) begin
          main_q  <= skid_q;
          state_q <= HALF;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= EMPTY;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign {mem_addr_out, rdest_addr_out, data_out, head_st, head_pc} = main_q;
  assign store_out = head_st & out_valid;
  assign pc_wr_out = head_pc & out_valid;

endmodule

// File: tb/tb_exst_mem_pipe_stage.sv
// Directed bench for exst_mem_pipe_stage: a queue model checked every cycle,
// plus literal expectations at key points; SKID=1 default and SKID=0 wide variants.
module tb_exst_mem_pipe_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit started = 1'b0;

  // DUT A: SKID=1, default widths
  logic        a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [15:0] a_mem_addr_in = 0, a_mem_addr_out;
  logic [2:0]  a_rdest_addr_in = 0, a_rdest_addr_out;
  logic [31:0] a_data_in = 0, a_data_out;
  logic        a_store_in = 0, a_pc_wr_in = 0, a_store_out, a_pc_wr_out;
  logic [1:0]  a_occupancy;

  // DUT B: SKID=0, ADDR_W=32, DATA_W=64
  logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [31:0] b_mem_addr_in = 0, b_mem_addr_out;
  logic [2:0]  b_rdest_addr_in = 0, b_rdest_addr_out;
  logic [63:0] b_data_in = 0, b_data_out;
  logic        b_store_in = 0, b_pc_wr_in = 0, b_store_out, b_pc_wr_out;
  logic [1:0]  b_occupancy;

  exst_mem_pipe_stage dut_a (
    .clk(clk), .reset(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .mem_addr_in(a_mem_addr_in), .rdest_addr_in(a_rdest_addr_in), .data_in(a_data_in),
    .store_in(a_store_in), .pc_wr_in(a_pc_wr_in),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .mem_addr_out(a_mem_addr_out), .rdest_addr_out(a_rdest_addr_out), .data_out(a_data_out),
    .store_out(a_store_out), .pc_wr_out(a_pc_wr_out), .occupancy(a_occupancy));

  exst_mem_pipe_stage #(.ADDR_W(32), .RADDR_W(3), .DATA_W(64), .SKID(1'b0)) dut_b (
    .clk(clk), .reset(rst), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mem_addr_in(b_mem_addr_in), .rdest_addr_in(b_rdest_addr_in), .data_in(b_data_in),
    .store_in(b_store_in), .pc_wr_in(b_pc_wr_in),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .mem_addr_out(b_mem_addr_out), .rdest_addr_out(b_rdest_addr_out), .data_out(b_data_out),
    .store_out(b_store_out), .pc_wr_out(b_pc_wr_out), .occupancy(b_occupancy));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a FIFO of accepted beats; capacity 2 (A) or 1 with pass-through (B).
  logic [52:0]  qa[$];
  logic [100:0] qb[$];

  always @(posedge clk) begin
    bit rdy, pp, ps;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      rdy = (qa.size() < 2);
      pp  = (qa.size() > 0) && a_out_ready;
      ps  = a_in_valid && rdy;
      if (flush) qa.delete();
      else begin
        if (pp) void'(qa.pop_front());
        if (ps) qa.push_back({a_mem_addr_in, a_rdest_addr_in, a_data_in, a_store_in, a_pc_wr_in});
      end
      rdy = (qb.size() == 0) || b_out_ready;
      pp  = (qb.size() > 0) && b_out_ready;
      ps  = b_in_valid && rdy;
      if (flush) qb.delete();
      else begin
        if (pp) void'(qb.pop_front());
        if (ps) qb.push_back({b_mem_addr_in, b_rdest_addr_in, b_data_in, b_store_in, b_pc_wr_in});
      end
    end
  end

  always @(negedge clk) begin
    if (started && rst) begin
      chk("a_ready_in_reset", a_in_ready, 0);
      chk("b_ready_in_reset", b_in_ready, 0);
    end else if (started) begin
      chk("a_occ", a_occupancy, qa.size());
      chk("a_in_ready", a_in_ready, qa.size() < 2);
      chk("a_out_valid", a_out_valid, qa.size() > 0);
      chk("a_store_out", a_store_out, (qa.size() > 0) ? qa[0][1] : 1'b0);
      chk("a_pc_wr_out", a_pc_wr_out, (qa.size() > 0) ? qa[0][0] : 1'b0);
      if (qa.size() > 0) begin
        chk("a_mem_addr", a_mem_addr_out, qa[0][52:37]);
        chk("a_rdest", a_rdest_addr_out, qa[0][36:34]);
        chk("a_data", a_data_out, qa[0][33:2]);
      end
      chk("b_occ", b_occupancy, qb.size());
      chk("b_in_ready", b_in_ready, (qb.size() == 0) || b_out_ready);
      chk("b_out_valid", b_out_valid, qb.size() > 0);
      chk("b_store_out", b_store_out, (qb.size() > 0) ? qb[0][1] : 1'b0);
      chk("b_pc_wr_out", b_pc_wr_out, (qb.size() > 0) ? qb[0][0] : 1'b0);
      if (qb.size() > 0) begin
        chk("b_mem_addr", b_mem_addr_out, qb[0][100:69]);
        chk("b_rdest", b_rdest_addr_out, qb[0][68:66]);
        chk("b_data", b_data_out, qb[0][65:2]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [15:0] ad, input logic [31:0] d,
                         input logic st, input logic pc);
    a_in_valid = v; a_mem_addr_in = ad; a_data_in = d;
    a_rdest_addr_in = d[2:0]; a_store_in = st; a_pc_wr_in = pc;
  endtask

  initial begin
    // Reset, then fill A to FULL with stores and reset mid-stall.
    tick();
    started = 1'b1;
    tick();
    rst = 1'b0;
    a_out_ready = 0;
    a_drive(1, 16'h0100, 32'hA1, 1, 0); tick();
    a_drive(1, 16'h0104, 32'hA2, 1, 1); tick();
    a_drive(0, 0, 0, 0, 0);
    chk("t1_occ_full", a_occupancy, 2);
    chk("t1_ready_full", a_in_ready, 0);
    rst = 1'b1;
    #1 chk("t1_ready_during_reset", a_in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("t1_valid_after_reset", a_out_valid, 0);
    chk("t1_occ_after_reset", a_occupancy, 0);
    chk("t1_store_after_reset", a_store_out, 0);
    chk("t1_ready_after_reset", a_in_ready, 1);

    // Streaming, 1 beat/cycle.
    a_out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      a_drive(1, 16'(i * 4), 32'(i), 0, 0);
      tick();
      chk("t2_data", a_data_out, 32'(i));
      chk("t2_occ", a_occupancy, 1);
    end
    a_drive(0, 0, 0, 0, 0); tick();
    chk("t2_drained", a_out_valid, 0);

    // Skid fill, hold-off and ordered drain.
    a_out_ready = 0;
    a_drive(1, 16'h11, 32'h11, 0, 0); tick();
    a_drive(1, 16'h22, 32'h22, 0, 0); tick();
    chk("t3_occ2", a_occupancy, 2);
    chk("t3_ready0", a_in_ready, 0);
    a_drive(1, 16'h33, 32'h33, 0, 0); tick(); tick();
    chk("t3_held_occ", a_occupancy, 2);
    chk("t3_held_head", a_data_out, 32'h11);
    a_out_ready = 1; tick();
    chk("t3_second", a_data_out, 32'h22);
    tick();
    chk("t3_third", a_data_out, 32'h33);
    a_drive(0, 0, 0, 0, 0); tick();
    chk("t3_empty", a_occupancy, 0);

    // Flush on the capture cycle, then flush while FULL.
    a_drive(1, 16'h1234, 32'h55, 1, 0);
    flush = 1; tick();
    flush = 0; a_drive(0, 0, 0, 0, 0);
    chk("t4_flush_valid", a_out_valid, 0);
    chk("t4_flush_store", a_store_out, 0);
    tick();
    chk("t4_flush_valid2", a_out_valid, 0);
    a_out_ready = 0;
    a_drive(1, 16'h1234, 32'h66, 1, 0); tick();
    a_drive(1, 16'h1238, 32'h67, 1, 0); tick();
    chk("t4_full", a_occupancy, 2);
    a_drive(0, 0, 0, 0, 0);
    flush = 1; tick(); flush = 0;
    chk("t4_full_flush_occ", a_occupancy, 0);
    chk("t4_full_flush_store", a_store_out, 0);
    tick();

    // pc_wr on one beat only, across a 3-cycle stall.
    a_out_ready = 1;
    a_drive(1, 16'h40, 32'h70, 0, 0); tick();
    chk("t5_pc_before", a_pc_wr_out, 0);
    a_drive(1, 16'h44, 32'h71, 0, 1); tick();
    chk("t5_pc_head", a_pc_wr_out, 1);
    a_out_ready = 0;
    a_drive(1, 16'h48, 32'h72, 0, 0); tick();
    chk("t5_pc_stall1", a_pc_wr_out, 1);
    a_drive(0, 0, 0, 0, 0); tick();
    chk("t5_pc_stall2", a_pc_wr_out, 1);
    tick();
    chk("t5_pc_stall3", a_pc_wr_out, 1);
    chk("t5_addr_stable", a_mem_addr_out, 16'h44);
    a_out_ready = 1; tick();
    chk("t5_pc_after", a_pc_wr_out, 0);
    chk("t5_after_data", a_data_out, 32'h72);
    tick();
    chk("t5_pc_bubble", a_pc_wr_out, 0);

    // SKID=0 wide variant.
    b_out_ready = 0;
    #1 chk("t6_ready_empty", b_in_ready, 1);
    b_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1;
      b_mem_addr_in = 32'hF000_0000 + 32'(i);
      b_data_in = {32'hDEAD_0000 + 32'(i), 32'(i)};
      b_rdest_addr_in = 3'(i);
      b_store_in = i[0];
      tick();
      chk("t6_data", b_data_out, {32'hDEAD_0000 + 32'(i), 32'(i)});
      chk("t6_occ", b_occupancy, 1);
      chk("t6_ready", b_in_ready, 1);
    end
    b_out_ready = 0;
    #1 chk("t6_ready_stall", b_in_ready, 0);
    tick();
    chk("t6_hold", b_data_out, {32'hDEAD_0003, 32'd3});
    b_out_ready = 1;
    #1 chk("t6_ready_resume", b_in_ready, 1);
    tick();
    b_in_valid = 0; tick(); tick();
    chk("t6_drained", b_out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
